// File: rtl/s_mem_scheduler.sv
// S-memory phase sequencer: runs init -> ksa -> dec and muxes the owner's write port.
// Optional ack watchdog with ERR state: define SCHED_WATCHDOG_EN.
module s_mem_scheduler #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              init_start,
  output logic              ksa_start,
  output logic              dec_start,
  input  logic              init_finish,
  input  logic              ksa_finish,
  input  logic              dec_finish,
  input  logic              init_we,
  input  logic              ksa_we,
  input  logic              dec_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic [DATA_W-1:0] dec_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_REQ,
    S_INIT_RUN,
    S_KSA_REQ,
    S_KSA_RUN,
    S_DEC_REQ,
    S_DEC_RUN,
    S_DONE
`ifdef SCHED_WATCHDOG_EN
    , S_ERR
`endif
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic             in_req;
  logic             own_fin;
  logic             wd_hit;
  logic [CNT_W-1:0] wd_cnt;

  assign in_req = (state == S_INIT_REQ) ||
                  (state == S_KSA_REQ)  ||
                  (state == S_DEC_REQ);
  assign wd_hit = (wd_cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    own_fin = 1'b0;
    unique case (state)
      S_INIT_REQ: own_fin = init_finish;
      S_KSA_REQ:  own_fin = ksa_finish;
      S_DEC_REQ:  own_fin = dec_finish;
      default:    own_fin = 1'b0;
    endcase
  end

  // Outside REQ the count sits at zero, so every REQ entry starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wd_cnt <= '0;
    else if (in_req && own_fin) wd_cnt <= wd_cnt + 1'b1;
    else                      wd_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT != 0);
`endif

  // Finish is idle-high, so REQ only waits for it to fall (ack).
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (go)           state_nx = S_INIT_REQ;
      S_INIT_REQ: if (!init_finish) state_nx = S_INIT_RUN;
      S_INIT_RUN: if (init_finish)  state_nx = S_KSA_REQ;
      S_KSA_REQ:  if (!ksa_finish)  state_nx = S_KSA_RUN;
      S_KSA_RUN:  if (ksa_finish)   state_nx = S_DEC_REQ;
      S_DEC_REQ:  if (!dec_finish)  state_nx = S_DEC_RUN;
      S_DEC_RUN:  if (dec_finish)   state_nx = S_DONE;
      S_DONE:     if (!go)          state_nx = S_IDLE;
`ifdef SCHED_WATCHDOG_EN
      S_ERR:                        state_nx = S_ERR;
`endif
      default:                      state_nx = S_IDLE;
    endcase
`ifdef SCHED_WATCHDOG_EN
    if (in_req && own_fin && wd_hit) state_nx = S_ERR;
`endif
  end

  always_comb begin
    init_start = (state == S_INIT_REQ);
    ksa_start  = (state == S_KSA_REQ);
    dec_start  = (state == S_DEC_REQ);
    done       = (state == S_DONE);
`ifdef SCHED_WATCHDOG_EN
    err        = (state == S_ERR);
`else
    err        = 1'b0;
`endif
    phase = 2'b00;
    unique case (state)
      S_INIT_REQ, S_INIT_RUN: phase = 2'b01;
      S_KSA_REQ,  S_KSA_RUN:  phase = 2'b10;
      S_DEC_REQ,  S_DEC_RUN:  phase = 2'b11;
      default:                phase = 2'b00;
    endcase
    busy = (phase != 2'b00);
  end

  // Only the owner's port reaches memory; non-owner writes are dropped.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    unique case (phase)
      2'b01: begin
        mem_we   = init_we;
        mem_addr = init_addr;
        mem_data = init_data;
      end
      2'b10: begin
        mem_we   = ksa_we;
        mem_addr = ksa_addr;
        mem_data = ksa_data;
      end
      2'b11: begin
        mem_we   = dec_we;
        mem_addr = dec_addr;
        mem_data = dec_data;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_s_mem_scheduler.sv
// Bench for s_mem_scheduler: vector table, handshake sequences, random vs model.
// Watchdog scenarios follow SCHED_WATCHDOG_EN.
module tb_s_mem_scheduler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [2:0] fin;
  logic [2:0] we;
  logic [7:0] addr [3];
  logic [7:0] data [3];
  logic       init_start, ksa_start, dec_start;
  logic       mem_we;
  logic [7:0] mem_addr, mem_data;
  logic [1:0] phase;
  logic       busy, done, err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  s_mem_scheduler #(.ADDR_W(8), .DATA_W(8), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
    .init_finish(fin[0]), .ksa_finish(fin[1]), .dec_finish(fin[2]),
    .init_we(we[0]), .ksa_we(we[1]), .dec_we(we[2]),
    .init_addr(addr[0]), .ksa_addr(addr[1]), .dec_addr(addr[2]),
    .init_data(data[0]), .ksa_data(data[1]), .dec_data(data[2]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .phase(phase), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int         ph;
    logic [2:0] we;
    logic [7:0] a0, a1, a2, d0, d1, d2;
    logic       ewe;
    logic [7:0] ea, ed;
  } vec_t;

  function automatic vec_t mk(input int ph, input logic [2:0] w,
                              input logic [7:0] a0, a1, a2, d0, d1, d2,
                              input logic ewe, input logic [7:0] ea, ed);
    vec_t v;
    v.ph = ph; v.we = w;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.ewe = ewe; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic logic [2:0] starts();
    return {dec_start, ksa_start, init_start};
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    go = 1'b0;
    fin = 3'b111;
    #2;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Walk the DUT to table phase t (0 idle, 1..3 owner RUN, 4 done).
  int cur;
  task automatic advance_to(input int t);
    while (cur < t) begin
      case (cur)
        0: begin go = 1'b1; tick(); fin[0] = 1'b0; tick(); end
        1: begin fin[0] = 1'b1; tick(); fin[1] = 1'b0; tick(); end
        2: begin fin[1] = 1'b1; tick(); fin[2] = 1'b0; tick(); end
        default: begin fin[2] = 1'b1; tick(); end
      endcase
      cur++;
    end
  endtask

  // Client model: ack one cycle after start, stay busy for run cycles.
  task automatic serve(input int i, input int run);
    int w = 0;
    logic [2:0] sv;
    sv = starts();
    while (sv[i] !== 1'b1 && w < 50) begin
      tick();
      sv = starts();
      w++;
    end
    if (w >= 50) begin
      timeout($sformatf("serve%0d_start", i));
      return;
    end
    chk($sformatf("serve%0d_req_phase", i), phase, i + 1);
    chk($sformatf("serve%0d_onehot", i), sv, 3'b001 << i);
    tick();
    fin[i] = 1'b0;
    tick();
    chk($sformatf("serve%0d_run_start", i), starts(), 0);
    chk($sformatf("serve%0d_run_phase", i), phase, i + 1);
    repeat (run - 1) tick();
    fin[i] = 1'b1;
    tick();
  endtask

  // Reference model: position in the init/ksa/dec sequence plus REQ flag.
  int m_k;
  bit m_req;
  int m_wd;

  function automatic logic [24:0] model_out();
    logic [1:0] ph;
    logic [2:0] st;
    logic       w;
    logic [7:0] a, d;
    ph = 2'b00; st = 3'b000; w = 1'b0; a = 8'h00; d = 8'h00;
    if (m_k >= 1 && m_k <= 3) begin
      ph = 2'(m_k);
      if (m_req) st = 3'(1 << (m_k - 1));
      w = we[m_k-1];
      a = addr[m_k-1];
      d = data[m_k-1];
    end
    return {ph, ph != 2'b00, m_k == 4, m_k == 5, st, w, a, d};
  endfunction

  function automatic logic [24:0] dut_out();
    return {phase, busy, done, err, dec_start, ksa_start, init_start,
            mem_we, mem_addr, mem_data};
  endfunction

  task automatic model_step();
    if (m_k == 0) begin
      if (go) begin m_k = 1; m_req = 1; m_wd = 0; end
    end else if (m_k >= 1 && m_k <= 3) begin
      if (m_req) begin
        if (!fin[m_k-1]) m_req = 0;
        else begin
`ifdef SCHED_WATCHDOG_EN
          if (m_wd == TO - 1) begin m_k = 5; m_req = 0; end
          else m_wd++;
`else
          m_wd++;
`endif
        end
      end else if (fin[m_k-1]) begin
        if (m_k == 3) m_k = 4;
        else begin m_k++; m_req = 1; m_wd = 0; end
      end
    end else if (m_k == 4) begin
      if (!go) m_k = 0;
    end
  endtask

  vec_t tv [9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = mk(0, 3'b111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 0, 8'h00, 8'h00);
    tv[1] = mk(1, 3'b011, 8'h05, 8'hAA, 8'h33, 8'h05, 8'hAA, 8'h66, 1, 8'h05, 8'h05);
    tv[2] = mk(1, 3'b010, 8'h12, 8'hAA, 8'h34, 8'h56, 8'hAA, 8'h78, 0, 8'h12, 8'h56);
    tv[3] = mk(1, 3'b111, 8'hFF, 8'h01, 8'h02, 8'h80, 8'h03, 8'h04, 1, 8'hFF, 8'h80);
    tv[4] = mk(2, 3'b010, 8'h05, 8'h33, 8'h77, 8'h05, 8'h44, 8'h88, 1, 8'h33, 8'h44);
    tv[5] = mk(2, 3'b101, 8'h01, 8'h9C, 8'h02, 8'h03, 8'hC9, 8'h04, 0, 8'h9C, 8'hC9);
    tv[6] = mk(3, 3'b100, 8'h01, 8'h02, 8'hE7, 8'h03, 8'h04, 8'h7E, 1, 8'hE7, 8'h7E);
    tv[7] = mk(3, 3'b011, 8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'hFF, 0, 8'h00, 8'hFF);
    tv[8] = mk(4, 3'b111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 0, 8'h00, 8'h00);

    // Reset state, with client writes active to prove masking.
    reset = 1'b1; go = 1'b0; fin = 3'b111; we = 3'b111;
    addr[0] = 8'h5A; addr[1] = 8'hA5; addr[2] = 8'h3C;
    data[0] = 8'hC3; data[1] = 8'h0F; data[2] = 8'hF0;
    #3;
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_starts", starts(), 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_no_go", phase, 0);

    // Port ownership table.
    cur = 0;
    for (int j = 0; j < 9; j++) begin
      advance_to(tv[j].ph);
      we = tv[j].we;
      addr[0] = tv[j].a0; addr[1] = tv[j].a1; addr[2] = tv[j].a2;
      data[0] = tv[j].d0; data[1] = tv[j].d1; data[2] = tv[j].d2;
      #1;
      chk($sformatf("tv%0d_phase", j), phase, (tv[j].ph == 4) ? 0 : tv[j].ph);
      chk($sformatf("tv%0d_mem_we", j), mem_we, tv[j].ewe);
      chk($sformatf("tv%0d_mem_addr", j), mem_addr, tv[j].ea);
      chk($sformatf("tv%0d_mem_data", j), mem_data, tv[j].ed);
    end
    chk("tv_done", done, 1);
    go = 1'b0; we = 3'b000;
    tick();
    chk("tv_back_idle", done, 0);

    // Nominal sequence with 16/32/8 cycle clients.
    go = 1'b1;
    serve(0, 16);
    serve(1, 32);
    serve(2, 8);
    chk("nom_done", done, 1);
    chk("nom_busy", busy, 0);
    chk("nom_phase", phase, 0);

    // go held in DONE must not restart.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold%0d", c), {done, busy, starts()}, 5'b10000);
    end
    go = 1'b0;
    tick();
    chk("drop_idle", {done, busy, phase}, 4'b0000);
    go = 1'b1;
    tick();
    chk("rise_init_req", {init_start, phase}, 3'b101);

    // Reset while KSA_REQ drives start and a ksa write.
    fin[0] = 1'b0; tick();
    fin[0] = 1'b1; tick();
    we = 3'b010; addr[1] = 8'hAA; data[1] = 8'h77;
    #1;
    chk("ksa_req_phase", {ksa_start, phase, mem_we}, 4'b1101);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ksa_start", ksa_start, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_phase", phase, 0);
    chk("arst_busy", busy, 0);
    go = 1'b0;
    tick();
    reset = 1'b0;
    we = 3'b000;
    go = 1'b1;
    tick();
    chk("restart_init", {starts(), phase}, 5'b00101);

    // Stuck ksa ack.
    fin[0] = 1'b0; tick();
    fin[0] = 1'b1; tick();
    chk("wd_ksa_req", ksa_start, 1);
`ifdef SCHED_WATCHDOG_EN
    begin
      int n = 0;
      while (err !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("wd_err_cycles", n, TO);
      chk("wd_ksa_start", ksa_start, 0);
      chk("wd_busy_done", {busy, done}, 0);
      go = 1'b0; tick(); tick();
      go = 1'b1; tick(); tick();
      chk("wd_sticky", {err, phase, starts()}, 6'b100000);
      pulse_reset();
      chk("wd_clear", err, 0);
    end
`else
    repeat (1000) tick();
    chk("nowd_ksa_start", ksa_start, 1);
    chk("nowd_err", err, 0);
    chk("nowd_phase", phase, 2);
    pulse_reset();
`endif

    // Random stimulus against the sequence model.
    pulse_reset();
    m_k = 0; m_req = 0; m_wd = 0;
    for (int c = 0; c < 600; c++) begin
      go = ($urandom % 10) < 7;
      fin = 3'($urandom);
      we = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        addr[i] = 8'($urandom);
        data[i] = 8'($urandom);
      end
      #1;
      chk($sformatf("rand%0d", c), dut_out(), model_out());
      model_step();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/s_mem_scheduler.md
Name: s_mem_scheduler

Overview:
Phase sequencer and port owner for the single-port 256x8 S memory in the RC4 datapath. On a go request it runs three client engines in a fixed order: S-init (00->FF fill), key-schedule shuffle (KSA), then decrypt. It hands each engine a start/finish handshake and muxes only the owning engine's write port onto the S memory. It sits between the top-level control and the three engines.

Parameters:
ADDR_W, 8, S memory address width
DATA_W, 8, S memory data width
ACK_TIMEOUT, 16, max cycles in a REQ state waiting for client ack (watchdog only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
go  in  1  level request to run the full sequence
init_start / ksa_start / dec_start  out  1 each  per-client start; level, held until the client acks
init_finish / ksa_finish / dec_finish  in  1 each  per-client level idle flag; low = running, high = idle/complete
init_we, ksa_we, dec_we  in  1 each  client write enables
init_addr, ksa_addr, dec_addr  in  ADDR_W each  client addresses
init_data, ksa_data, dec_data  in  DATA_W each  client write data
mem_we  out  1  S memory write enable
mem_addr  out  ADDR_W  S memory address
mem_data  out  DATA_W  S memory write data
phase  out  2  current owner: 00 none, 01 init, 10 ksa, 11 dec
busy  out  1  high in any REQ/RUN state
done  out  1  high in DONE
err  out  1  sticky watchdog error

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All *_start=0, mem_we=0, mem_addr=0, mem_data=0, phase=00, busy=0, done=0, err=0, watchdog count=0.
- States: IDLE, INIT_REQ, INIT_RUN, KSA_REQ, KSA_RUN, DEC_REQ, DEC_RUN, DONE, ERR. The state register is updated on posedge clk.
- IDLE: go=1 -> INIT_REQ.
- X_REQ (X = INIT/KSA/DEC):
  - x_start=1.
  - When x_finish==0 is sampled (ack), go to X_RUN; x_start drops in that same transition.
- X_RUN: x_start=0. When x_finish==1 is sampled, go to the next phase's REQ; DEC_RUN goes to DONE.
- DONE: done=1. When go==0, go to IDLE. A held go does not restart the sequence; go must drop and then rise again.
- go is sampled only in IDLE and DONE. Dropping go mid-sequence is ignored.
- Only one *_start is ever high at a time.
- Minimum per-phase overhead: 1 REQ cycle + 1 RUN exit cycle.
- Port mux (combinational from the registered state, 0 cycles latency):
  - phase=01 in INIT_*, 10 in KSA_*, 11 in DEC_*, 00 otherwise.
  - mem_we/addr/data = owner's we/addr/data.
  - Non-owner we is masked: it never reaches mem_we.
  - In IDLE, DONE and ERR: mem_we=0, mem_addr=0, mem_data=0.
- Client finish is a level signal that is high while the client is idle, including out of reset. The scheduler therefore must not treat finish=1 on entry to REQ as completion; completion is recognised only in RUN.
- Reset mid-operation: immediate return to IDLE. All starts and mem_we are forced low asynchronously. Clients are reset by the same reset.
- ERR is reached only with SCHED_WATCHDOG_EN. It is left only by reset. In ERR: all starts=0, busy=0, done=0, err=1.

Optional Feature:
SCHED_WATCHDOG_EN
- Defined:
  - A counter clears on entry to each REQ state and increments every REQ cycle while x_finish==1.
  - If the counter reaches ACK_TIMEOUT before ack, go to ERR and set err=1 (sticky).
- Undefined:
  - No counter and no ERR state; REQ waits indefinitely.
  - The err port exists but is tied 0.

Test Plan:
- Nominal sequence:
  - Stimulus: go=1. Client models ack 1 cycle after start, then run 16/32/8 cycles.
  - Required: start pulses in order init->ksa->dec; phase steps 01,10,11; done=1 after dec_finish rises; busy=0 in DONE.
- Port ownership:
  - Stimulus: during INIT_RUN drive init_addr=8'h05, init_data=8'h05, init_we=1, and ksa_we=1, ksa_addr=8'hAA.
  - Required: mem_addr=05, mem_data=05, mem_we=1; the ksa_* values never appear on the mem_* port.
- go hold/retrigger:
  - Stimulus: keep go=1 after DONE for 10 cycles, then go=0 for 1 cycle, then go=1.
  - Required: no restart while held; IDLE after go drops; INIT_REQ on the next rise.
- Reset mid-KSA:
  - Stimulus: assert reset for 1 cycle while phase=10.
  - Required: ksa_start=0, mem_we=0, phase=00, busy=0 immediately (asynchronous); the sequence restarts cleanly at init on the next go.
- Watchdog (macro defined, ACK_TIMEOUT=16):
  - Stimulus: ksa_finish stuck high.
  - Required: err=1 exactly 16 cycles after entering KSA_REQ; ksa_start=0; err stays 1 through a go toggle and clears only on reset.
- Watchdog off (macro undefined):
  - Stimulus: same stuck ack as the previous scenario.
  - Required: ksa_start held, err=0 after 1000 cycles.
